// File: rtl/count_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// A start request captures the binary count. The converter then shifts it through a
// BCD scratch register over WIDTH cycles. The result is published on bcd_out with a
// one-cycle bcd_valid pulse.
module count_bcd_converter #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count,
    input  logic                  start,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     out_q, out_d;
    logic                 valid_q, valid_d;

    logic [BCD_W-1:0]        corrected;
    logic [BCD_W+WIDTH-1:0]  shifted;

    // Add 3 to every digit that is 5 or more.
    // After the following left shift, such a digit carries into the next decade.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Next-state logic: FSM sequencing plus the shift-and-add-3 datapath.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        corrected = add3_digits(scratch_q);
        shifted   = {corrected, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = count;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[BCD_W+WIDTH-1:WIDTH];
                bin_d     = shifted[WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The final shift already happened, so the scratch digits are published uncorrected.
                out_d   = scratch_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
        end
    end

    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign bcd_valid = valid_q;
    assign bcd_out   = out_q;

endmodule

// File: tb/tb_count_bcd_converter.sv
// Bench for count_bcd_converter.
// Tasks push expected results and their due cycle into a queue. A negedge monitor pops
// and compares them whenever bcd_valid pulses.
module tb_count_bcd_converter;

    logic        clock;
    logic        reset;
    logic [9:0]  count;
    logic        start;
    logic        busy;
    logic        bcd_valid;
    logic [15:0] bcd_out;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] out_shadow = 16'h0000;

    count_bcd_converter #(.WIDTH(10), .DIGITS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .count    (count),
        .start    (start),
        .busy     (busy),
        .bcd_valid(bcd_valid),
        .bcd_out  (bcd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Decimal reference model: digit extraction by division.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Called just before the accepting edge. The result is due 11 edges after it.
    task automatic push_exp(input int v);
        exp_t e;
        e.val = to_bcd(v);
        e.cyc = cyc + 12;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every bcd_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && bcd_valid === 1'b1) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_valid: bcd_out=%h at cycle %0d, nothing expected", bcd_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bcd_out !== e.val) begin
                    bad = bad + 1;
                    $display("FAIL result: got %h expected %h", bcd_out, e.val);
                end
                total = total + 1;
                if (cyc !== e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL latency: valid at cycle %0d expected %0d", cyc, e.cyc);
                end
                out_shadow = e.val;
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        count = 10'd512;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total = total + 3;
            if (busy !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL reset_busy: got %b required 0", busy);
            end
            if (bcd_valid !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL reset_valid: got %b required 0", bcd_valid);
            end
            if (bcd_out !== 16'h0000) begin
                bad = bad + 1;
                $display("FAIL reset_out: got %h required 0000", bcd_out);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        push_exp(512);
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic test_basic();
        int vals[7] = '{0, 1, 9, 10, 99, 100, 999};
        foreach (vals[k]) begin
            @(negedge clock);
            count = 10'(vals[k]);
            start = 1'b1;
            push_exp(vals[k]);
            @(negedge clock);
            start = 1'b0;
            wait_drain();
        end
    endtask

    task automatic test_max();
        logic [15:0] prev;
        int          busy_cnt;
        prev = out_shadow;
        busy_cnt = 0;
        @(negedge clock);
        count = 10'd1023;
        start = 1'b1;
        push_exp(1023);
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            total = total + 1;
            if (bcd_out !== prev) begin
                bad = bad + 1;
                $display("FAIL max_hold: got %h required %h", bcd_out, prev);
            end
        end
        total = total + 1;
        if (busy_cnt != 11) begin
            bad = bad + 1;
            $display("FAIL max_busy_len: got %0d cycles required 11", busy_cnt);
        end
        @(negedge clock);
        total = total + 2;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL max_busy_fall: got %b required 0", busy);
        end
        if (bcd_out !== 16'h1023) begin
            bad = bad + 1;
            $display("FAIL max_out: got %h required 1023", bcd_out);
        end
        wait_drain();
    endtask

    task automatic test_handshake();
        @(negedge clock);
        count = 10'd45;
        start = 1'b1;
        push_exp(45);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        count = 10'd800;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        count = 10'd7;
        wait_drain();
        repeat (15) @(negedge clock);
    endtask

    task automatic test_back_to_back(input int first, input int n);
        @(negedge clock);
        start = 1'b1;
        count = 10'(first);
        push_exp(first);
        for (int k = 1; k < n; k++) begin
            repeat (12) @(negedge clock);
            count = 10'(first + k);
            push_exp(first + k);
        end
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        count = 10'd777;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        total = total + 3;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midreset_busy: got %b required 0", busy);
        end
        if (bcd_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midreset_valid: got %b required 0", bcd_valid);
        end
        if (bcd_out !== 16'h0000) begin
            bad = bad + 1;
            $display("FAIL midreset_out: got %h required 0000", bcd_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (15) @(negedge clock);
        count = 10'd321;
        start = 1'b1;
        push_exp(321);
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_handshake();
        test_back_to_back(0, 8);
        test_reset_mid();
        test_back_to_back(0, 1024);
        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
